// File: rtl/nn_inference_scheduler.sv
// nn_inference_scheduler
// Round-robin arbiter that time-shares one neural network accelerator between
// several requesters. It runs one forward pass per grant, reduces the output
// activations to an argmax class and returns it over a valid/ready response.
// It then resets the accelerator so that it leaves its done state.

module nn_inference_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int NUM_OUTPUTS    = 10,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    output logic [NUM_REQ-1:0]             grant,
    output logic [$clog2(NUM_REQ)-1:0]     in_sel,
    output logic                           acc_start,
    output logic                           acc_rst,
    input  logic                           fp_done,
    input  logic [16*NUM_OUTPUTS-1:0]      activations,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [$clog2(NUM_REQ)-1:0]     resp_id,
    output logic [$clog2(NUM_OUTPUTS)-1:0] resp_class,
    output logic [15:0]                    resp_max,
    output logic                           resp_err,
    output logic                           busy
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CLW = $clog2(NUM_OUTPUTS);
    localparam int TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BUSY,
        ARGMAX,
        FLUSH,
        RESP
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDW-1:0]     id;
    logic [IDW-1:0]     last_id;
    logic [TW-1:0]      timer;
    logic [CLW-1:0]     k;
    logic signed [15:0] act_reg [NUM_OUTPUTS];
    logic signed [15:0] best;
    logic [CLW-1:0]     best_idx;
    logic               err;

    logic               rr_found;
    logic [IDW-1:0]     rr_winner;
    int                 cand;
    logic [IDW-1:0]     cand_idx;

    // Round-robin search: the first requester after last_id, wrapping around.
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = int'(last_id) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_idx = IDW'(cand);
            if (!rr_found && req[cand_idx]) begin
                rr_found  = 1'b1;
                rr_winner = cand_idx;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state selection and the Moore outputs that are decoded from the state.
    always_comb begin
        state_next = state;
        grant      = '0;
        in_sel     = '0;
        acc_start  = 1'b0;
        acc_rst    = rst;
        resp_valid = 1'b0;
        resp_id    = '0;
        resp_class = '0;
        resp_max   = '0;
        resp_err   = 1'b0;
        busy       = (state != IDLE);
        if (state != IDLE) begin
            grant  = NUM_REQ'(1) << id;
            in_sel = id;
        end
        case (state)
            IDLE:    if (rr_found) state_next = START;
            START: begin
                acc_start  = 1'b1;
                state_next = BUSY;
            end
            BUSY: begin
                if (fp_done)                                state_next = ARGMAX;
                else if (timer == TW'(TIMEOUT_CYCLES - 1))  state_next = FLUSH;
            end
            ARGMAX:  if (k == CLW'(NUM_OUTPUTS - 1)) state_next = FLUSH;
            FLUSH: begin
                acc_rst    = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_id    = id;
                resp_class = best_idx;
                resp_max   = best;
                resp_err   = err;
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: grant latch, watchdog timer, activation capture and argmax scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id       <= '0;
            last_id  <= IDW'(NUM_REQ - 1);
            timer    <= '0;
            k        <= '0;
            best     <= '0;
            best_idx <= '0;
            err      <= 1'b0;
            for (int i = 0; i < NUM_OUTPUTS; i++) act_reg[i] <= '0;
        end else begin
            case (state)
                IDLE:  if (rr_found) id <= rr_winner;
                START: timer <= '0;
                BUSY: begin
                    timer <= timer + TW'(1);
                    if (fp_done) begin
                        for (int i = 0; i < NUM_OUTPUTS; i++) act_reg[i] <= activations[i*16 +: 16];
                        best     <= activations[15:0];
                        best_idx <= '0;
                        k        <= CLW'(1);
                    end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        err      <= 1'b1;
                        best     <= '0;
                        best_idx <= '0;
                    end
                end
                ARGMAX: begin
                    if (act_reg[k] > best) begin
                        best     <= act_reg[k];
                        best_idx <= k;
                    end
                    k <= k + CLW'(1);
                end
                RESP: begin
                    if (resp_ready) begin
                        last_id <= id;
                        err     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_inference_scheduler.sv
// Testbench for nn_inference_scheduler: a transaction-timeline reference model
// checked every cycle, an accelerator model, directed scenarios with literal
// expectations, and a randomized soak.

module tb_nn_inference_scheduler;

    localparam int NUM_REQ        = 4;
    localparam int NUM_OUTPUTS    = 10;
    localparam int TIMEOUT_CYCLES = 1024;
    localparam int NONE           = 32'h7fffffff;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  grant;
    logic [1:0]  in_sel;
    logic        acc_start;
    logic        acc_rst;
    logic        fp_done = 1'b0;
    logic [159:0] activations = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [1:0]  resp_id;
    logic [3:0]  resp_class;
    logic [15:0] resp_max;
    logic        resp_err;
    logic        busy;

    always #5 clk = ~clk;

    nn_inference_scheduler #(
        .NUM_REQ(NUM_REQ),
        .NUM_OUTPUTS(NUM_OUTPUTS),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .grant(grant),
        .in_sel(in_sel),
        .acc_start(acc_start),
        .acc_rst(acc_rst),
        .fp_done(fp_done),
        .activations(activations),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_id(resp_id),
        .resp_class(resp_class),
        .resp_max(resp_max),
        .resp_err(resp_err),
        .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            if (errors <= 50)
                $display("[TB] FAIL %s: actual %0h required %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic int rrPick(input int last, input logic [3:0] r);
        int c;
        for (int i = 1; i <= NUM_REQ; i++) begin
            c = (last + i) % NUM_REQ;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    function automatic void argmaxModel(input logic [159:0] a, output int cls, output logic [15:0] mx);
        int b;
        b   = $signed(a[15:0]);
        cls = 0;
        for (int i = 1; i < NUM_OUTPUTS; i++) begin
            if ($signed(a[i*16 +: 16]) > b) begin
                b   = $signed(a[i*16 +: 16]);
                cls = i;
            end
        end
        mx = 16'(b);
    endfunction

    // Reference model: one transaction at a time, described by its timeline.
    bit          m_serving = 1'b0;
    int          m_id      = 0;
    int          m_last    = NUM_REQ - 1;
    int          m_tstart  = 0;
    int          m_tresp   = NONE;
    bit          m_err     = 1'b0;
    int          m_class   = 0;
    logic [15:0] m_max     = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_serving = 1'b0;
            m_last    = NUM_REQ - 1;
            m_tresp   = NONE;
        end else if (!m_serving) begin
            if (req != 4'b0) begin
                m_id      = rrPick(m_last, req);
                m_serving = 1'b1;
                m_tstart  = cyc + 1;
                m_tresp   = NONE;
                m_err     = 1'b0;
            end
        end else if (m_tresp == NONE) begin
            if (cyc > m_tstart) begin
                if (fp_done) begin
                    argmaxModel(activations, m_class, m_max);
                    m_tresp = cyc + NUM_OUTPUTS + 1;
                end else if (cyc == m_tstart + TIMEOUT_CYCLES) begin
                    m_err   = 1'b1;
                    m_class = 0;
                    m_max   = '0;
                    m_tresp = cyc + 2;
                end
            end
        end else if (cyc >= m_tresp && resp_ready) begin
            m_serving = 1'b0;
            m_last    = m_id;
        end
        cyc++;
    end

    // Per-cycle comparison of every output against the model.
    bit e_rv;
    bit e_flush;
    always @(negedge clk) begin
        if (rst) begin
            checkOutput("rst_acc_rst", acc_rst, 1);
            checkOutput("rst_grant", grant, 0);
            checkOutput("rst_in_sel", in_sel, 0);
            checkOutput("rst_acc_start", acc_start, 0);
            checkOutput("rst_resp_valid", resp_valid, 0);
            checkOutput("rst_resp_fields", {resp_id, resp_class, resp_max, resp_err}, 0);
            checkOutput("rst_busy", busy, 0);
        end else begin
            e_rv    = m_serving && (m_tresp != NONE) && (cyc >= m_tresp);
            e_flush = m_serving && (m_tresp != NONE) && (cyc == m_tresp - 1);
            checkOutput("busy", busy, m_serving);
            checkOutput("grant", grant, m_serving ? (32'd1 << m_id) : 32'd0);
            checkOutput("in_sel", in_sel, m_serving ? m_id : 0);
            checkOutput("acc_start", acc_start, m_serving && (cyc == m_tstart));
            checkOutput("acc_rst", acc_rst, e_flush);
            checkOutput("resp_valid", resp_valid, e_rv);
            checkOutput("resp_id", resp_id, e_rv ? m_id : 0);
            checkOutput("resp_class", resp_class, e_rv ? m_class : 0);
            checkOutput("resp_max", resp_max, e_rv ? m_max : 16'h0);
            checkOutput("resp_err", resp_err, e_rv ? m_err : 1'b0);
        end
    end

    // Event log used by the directed scenarios.
    int start_cnt  = 0;
    int flush_cnt  = 0;
    int last_flush = -1;
    int first_done = -1;
    bit fp_prev    = 1'b0;
    always @(negedge clk) begin
        if (acc_start) start_cnt++;
        if (acc_rst && !rst) begin
            flush_cnt++;
            last_flush = cyc;
        end
        if (fp_done && !fp_prev) first_done = cyc;
        fp_prev = fp_done;
    end

    // Accelerator model: done rises acc_lat cycles after start and holds until reset.
    int                 acc_lat      = 5;
    int                 done_cyc     = -1;
    bit                 prev_acc_rst = 1'b0;
    logic signed [15:0] act_vals [NUM_OUTPUTS];

    task automatic accModel();
        if (prev_acc_rst) done_cyc = -1;
        if (acc_start) done_cyc = (acc_lat < 0) ? -1 : cyc + acc_lat;
        fp_done = (done_cyc >= 0) && (cyc >= done_cyc);
        for (int i = 0; i < NUM_OUTPUTS; i++)
            activations[i*16 +: 16] = fp_done ? act_vals[i] : 16'($urandom);
        prev_acc_rst = acc_rst;
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic rdy);
        @(posedge clk);
        #1;
        accModel();
        req        = r;
        resp_ready = rdy;
    endtask

    task automatic waitStart(input logic [3:0] r, input logic rdy, input int budget, input string name);
        int n;
        n = 0;
        do begin
            applyStimulus(r, rdy);
            n++;
        end while (!acc_start && n < budget);
        checkOutput(name, acc_start, 1);
    endtask

    task automatic waitResp(input logic [3:0] r, input logic rdy, input int budget, input string name);
        int n;
        n = 0;
        do begin
            applyStimulus(r, rdy);
            n++;
        end while (!resp_valid && n < budget);
        checkOutput(name, resp_valid, 1);
    endtask

    task automatic resetPulse();
        rst = 1'b1;
        #1;
        checkOutput("reset_now_acc_rst", acc_rst, 1);
        checkOutput("reset_now_busy", busy, 0);
        checkOutput("reset_now_grant", grant, 0);
        checkOutput("reset_now_resp_valid", resp_valid, 0);
        prev_acc_rst = 1'b1;
        done_cyc     = -1;
        fp_done      = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int s;
    int t;
    int f0;
    int sc0;
    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        for (int i = 0; i < NUM_OUTPUTS; i++) act_vals[i] = '0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single request with a tie between indices 2 and 3.
        $display("[TB] single request");
        act_vals = '{16'sd100, -16'sd5, 16'sd3000, 16'sd3000, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
        acc_lat  = 386;
        waitStart(4'b0001, 1'b0, 10, "t1_start");
        s  = cyc;
        f0 = flush_cnt;
        waitResp(4'b0000, 1'b0, 2000, "t1_resp_valid");
        t = cyc;
        checkOutput("t1_done_to_valid", t - first_done, 11);
        checkOutput("t1_start_to_valid", t - s, 386 + 11);
        checkOutput("t1_flush_count", flush_cnt - f0, 1);
        checkOutput("t1_flush_cycle", last_flush, t - 1);
        checkOutput("t1_resp_id", resp_id, 0);
        checkOutput("t1_resp_class", resp_class, 2);
        checkOutput("t1_resp_max", resp_max, 16'd3000);
        checkOutput("t1_resp_err", resp_err, 0);
        applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("t1_idle_after", busy, 0);

        // Fairness from reset with every requester asking.
        $display("[TB] fairness");
        resetPulse();
        acc_lat = 5;
        for (int p = 0; p < 5; p++) begin
            sc0 = start_cnt;
            waitStart(4'b1111, 1'b1, 20, "fair_start");
            checkOutput("fair_in_sel", in_sel, exp_order[p]);
            checkOutput("fair_grant", grant, 32'd1 << exp_order[p]);
            waitResp(4'b1111, 1'b1, 100, "fair_resp_valid");
            checkOutput("fair_resp_id", resp_id, exp_order[p]);
            checkOutput("fair_in_sel_resp", in_sel, exp_order[p]);
            checkOutput("fair_start_count", start_cnt - sc0, 1);
        end
        applyStimulus(4'b0000, 1'b0);
        applyStimulus(4'b0000, 1'b0);

        // Watchdog expiry, then a normal pass.
        $display("[TB] watchdog");
        acc_lat = -1;
        waitStart(4'b0100, 1'b0, 10, "wd_start");
        s  = cyc;
        f0 = flush_cnt;
        waitResp(4'b0000, 1'b0, TIMEOUT_CYCLES + 50, "wd_resp_valid");
        checkOutput("wd_resp_time", cyc, s + 2 + TIMEOUT_CYCLES);
        checkOutput("wd_resp_err", resp_err, 1);
        checkOutput("wd_resp_class", resp_class, 0);
        checkOutput("wd_resp_max", resp_max, 0);
        checkOutput("wd_resp_id", resp_id, 2);
        checkOutput("wd_flush_count", flush_cnt - f0, 1);
        checkOutput("wd_flush_cycle", last_flush, cyc - 1);
        applyStimulus(4'b0000, 1'b1);
        acc_lat  = 20;
        act_vals = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd50, 16'sd6, 16'sd7, 16'sd8, 16'sd9, 16'sd10};
        waitStart(4'b1000, 1'b0, 10, "wd_next_start");
        waitResp(4'b0000, 1'b0, 100, "wd_next_resp_valid");
        checkOutput("wd_next_err", resp_err, 0);
        checkOutput("wd_next_class", resp_class, 4);
        checkOutput("wd_next_latency", cyc - first_done, 11);
        applyStimulus(4'b0000, 1'b1);

        // Backpressure held for 20 cycles in the response phase.
        $display("[TB] backpressure");
        acc_lat  = 3;
        act_vals = '{16'sd0, 16'sd10, 16'sd20, 16'sd30, 16'sd40, 16'sd1234, 16'sd60, 16'sd70, 16'sd80, 16'sd90};
        waitStart(4'b0001, 1'b0, 10, "bp_start");
        waitResp(4'b0000, 1'b0, 100, "bp_resp_valid");
        sc0 = start_cnt;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(4'b1111, 1'b0);
            checkOutput("bp_valid", resp_valid, 1);
            checkOutput("bp_class", resp_class, 5);
            checkOutput("bp_max", resp_max, 16'd1234);
            checkOutput("bp_id", resp_id, 0);
            checkOutput("bp_grant", grant, 4'b0001);
            checkOutput("bp_no_start", acc_start, 0);
        end
        applyStimulus(4'b1111, 1'b1);
        applyStimulus(4'b1111, 1'b0);
        checkOutput("bp_idle", busy, 0);
        checkOutput("bp_idle_grant", grant, 0);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("bp_next_start", acc_start, 1);
        checkOutput("bp_next_grant", grant, 4'b0010);
        checkOutput("bp_start_count", start_cnt - sc0, 0);
        waitResp(4'b0000, 1'b1, 100, "bp_next_resp_valid");
        applyStimulus(4'b0000, 1'b0);

        // All-negative activations with the maximum at the last index.
        $display("[TB] negative activations");
        for (int i = 0; i < NUM_OUTPUTS - 1; i++) act_vals[i] = 16'(-1000 - 37 * i);
        act_vals[NUM_OUTPUTS-1] = -16'sd7;
        acc_lat = 12;
        waitStart(4'b0001, 1'b0, 10, "neg_start");
        waitResp(4'b0000, 1'b0, 100, "neg_resp_valid");
        checkOutput("neg_class", resp_class, 9);
        checkOutput("neg_max", resp_max, 16'hFFF9);
        applyStimulus(4'b0000, 1'b1);

        // Reset during BUSY cycle 100.
        $display("[TB] reset mid-busy");
        acc_lat = 500;
        waitStart(4'b0010, 1'b0, 10, "rb_start");
        repeat (101) applyStimulus(4'b0000, 1'b0);
        checkOutput("rb_busy_before", busy, 1);
        resetPulse();
        acc_lat = 8;
        waitStart(4'b1111, 1'b0, 10, "rb_restart");
        checkOutput("rb_in_sel", in_sel, 0);
        checkOutput("rb_grant", grant, 4'b0001);
        waitResp(4'b0000, 1'b1, 100, "rb_resp_valid");
        applyStimulus(4'b0000, 1'b0);

        // Randomized soak: random requests, backpressure, latencies and activations.
        $display("[TB] random soak");
        for (int n = 0; n < 20000; n++) begin
            case ($urandom % 16)
                0:       acc_lat = -1;
                1:       acc_lat = TIMEOUT_CYCLES;
                2:       acc_lat = TIMEOUT_CYCLES - 1;
                3:       acc_lat = TIMEOUT_CYCLES + 1;
                default: acc_lat = $urandom_range(1, 30);
            endcase
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
                if ($urandom % 4 == 0) act_vals[i] = 16'($urandom);
                else                   act_vals[i] = 16'(($urandom_range(0, 6) - 3) * 1000);
            end
            applyStimulus(($urandom % 4 == 0) ? 4'b0000 : 4'($urandom), ($urandom % 5) < 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
